aes_enc_arbiter: RTL and testbench

- Shares one byte-serial AES-128 encryption core between NUM_REQ requesters, each presenting a full 128-bit key and block.
- Round-robin arbitration picks one request, serializes key and plaintext into the core and waits for completion.
- Collects the 16 ciphertext bytes and returns a 128-bit response tagged with the requester index.
- Sits between the crypto command fabric and the encryption core; it is the core's only driver.

---
 rtl/aes_enc_arbiter_pkg.sv | 23 ++
 rtl/aes_enc_arbiter_rr_arbiter.sv | 44 ++++
 rtl/aes_enc_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_enc_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_enc_arbiter_pkg.sv
// Shared definitions for the AES encryption-core arbiter.
// Holds the block sizes, the job FSM encoding and the big-endian byte-slice helper.
package aes_pkg;

   localparam int AES_BYTES = 16;
   localparam int AES_W     = 128;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_RESP  = 3'd5
   } aes_state_e;

   // Byte idx of a 128-bit word; byte 0 is the most significant byte.
   function automatic logic [7:0] byte_sel(input logic [AES_W-1:0] vec,
                                           input logic [3:0]       idx);
      byte_sel = vec[{~idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/aes_enc_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr,
// wrapping around, and reports the one-hot grant plus its index.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any_gnt
);

   localparam int IW = $clog2(N);
   localparam int SW = IW + 1;
   localparam logic [SW-1:0] N_W = SW'(N);

   logic [SW-1:0] sum_s;
   logic [IW-1:0] cand_s;

   // Walk the requesters starting at ptr; the first hit wins.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any_gnt = 1'b0;
      sum_s   = '0;
      cand_s  = '0;
      for (int k = 0; k < N; k++) begin
         sum_s = {1'b0, ptr} + SW'(k);
         if (sum_s >= N_W) begin
            cand_s = IW'(sum_s - N_W);
         end else begin
            cand_s = IW'(sum_s);
         end
         if (!any_gnt && req[cand_s]) begin
            gnt[cand_s] = 1'b1;
            idx         = cand_s;
            any_gnt     = 1'b1;
         end else begin
            any_gnt = any_gnt;
         end
      end
   end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one byte-serial AES-128 core between NUM_REQ requesters: arbitrates,
// serializes key/plaintext into the core, collects the ciphertext and responds.
module aes_enc_arbiter
   import aes_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*AES_W-1:0]   req_key,
   input  logic [NUM_REQ*AES_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [AES_W-1:0]           rsp_data,
   output logic                       rsp_err,
   output logic                       busy,
   output logic                       aes_enable,
   output logic [7:0]                 aes_key_byte,
   output logic [7:0]                 aes_state_byte,
   input  logic                       aes_load,
   input  logic                       aes_ready,
   input  logic [7:0]                 aes_out_byte
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX    = WDW'(TIMEOUT);
   localparam logic [3:0]     LAST_BYTE = 4'(AES_BYTES - 1);

   aes_state_e       state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [AES_W-1:0] key_sh_q, key_sh_d;
   logic [AES_W-1:0] data_sh_q, data_sh_d;
   logic [AES_W-1:0] out_sh_q, out_sh_d;
   logic [IW-1:0]    id_q, id_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WDW-1:0]   wdog_q, wdog_d;

   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]      rsp_id_q, rsp_id_d;
   logic [AES_W-1:0]   rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               busy_q, busy_d;
   logic               aes_enable_q, aes_enable_d;
   logic [7:0]         key_byte_q, key_byte_d;
   logic [7:0]         state_byte_q, state_byte_d;

   logic [NUM_REQ-1:0] gnt_s;
   logic [IW-1:0]      gnt_idx_s;
   logic               gnt_any_s;
   logic [AES_W-1:0]   key_sel_s;
   logic [AES_W-1:0]   data_sel_s;
   logic               aes_load_unused;

   // The core's load strobe is only of interest to external property checkers.
   assign aes_load_unused = aes_load;

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt_s),
      .idx     (gnt_idx_s),
      .any_gnt (gnt_any_s)
   );

   // One-hot mux of the granted requester's key and plaintext.
   always_comb begin
      key_sel_s  = '0;
      data_sel_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         key_sel_s  = key_sel_s  | (req_key[i*AES_W +: AES_W]  & {AES_W{gnt_s[i]}});
         data_sel_s = data_sel_s | (req_data[i*AES_W +: AES_W] & {AES_W{gnt_s[i]}});
      end
   end

   // Job FSM: next state, shadow registers and registered outputs.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      key_sh_d     = key_sh_q;
      data_sh_d    = data_sh_q;
      out_sh_d     = out_sh_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      wdog_d       = wdog_q;
      req_ready_d  = '0;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = '0;
      rsp_data_d   = '0;
      rsp_err_d    = 1'b0;
      aes_enable_d = aes_enable_q;
      key_byte_d   = 8'h00;
      state_byte_d = 8'h00;

      case (state_q)
         ST_IDLE: begin
            aes_enable_d = 1'b0;
            if (gnt_any_s) begin
               req_ready_d = gnt_s;
               key_sh_d    = key_sel_s;
               data_sh_d   = data_sel_s;
               out_sh_d    = '0;
               id_d        = gnt_idx_s;
               if (int'(gnt_idx_s) == NUM_REQ - 1) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = gnt_idx_s + IW'(1);
               end
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            aes_enable_d = 1'b1;
            cnt_d        = 4'd0;
            key_byte_d   = byte_sel(key_sh_q, 4'd0);
            state_byte_d = byte_sel(data_sh_q, 4'd0);
            state_d      = ST_LOAD;
         end
         ST_LOAD: begin
            // Output bytes are registered, so fetch the byte for the next cycle.
            if (cnt_q == LAST_BYTE) begin
               wdog_d  = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d        = cnt_q + 4'd1;
               key_byte_d   = byte_sel(key_sh_q, cnt_q + 4'd1);
               state_byte_d = byte_sel(data_sh_q, cnt_q + 4'd1);
            end
         end
         ST_WAIT: begin
            if (aes_ready) begin
               cnt_d   = 4'd0;
               state_d = ST_DRAIN;
            end else if (wdog_q == WD_MAX) begin
               aes_enable_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b1;
               rsp_id_d     = id_q;
               state_d      = ST_RESP;
            end else begin
               wdog_d = wdog_q + WDW'(1);
            end
         end
         ST_DRAIN: begin
            if (!aes_ready) begin
               aes_enable_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b1;
               rsp_id_d     = id_q;
               state_d      = ST_RESP;
            end else begin
               out_sh_d[{~cnt_q, 3'b000} +: 8] = aes_out_byte;
               if (cnt_q == LAST_BYTE) begin
                  aes_enable_d = 1'b0;
                  rsp_valid_d  = 1'b1;
                  rsp_id_d     = id_q;
                  rsp_data_d   = out_sh_d;
                  state_d      = ST_RESP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_RESP: begin
            aes_enable_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            aes_enable_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         key_sh_q     <= '0;
         data_sh_q    <= '0;
         out_sh_q     <= '0;
         id_q         <= '0;
         cnt_q        <= 4'd0;
         wdog_q       <= '0;
         req_ready_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         aes_enable_q <= 1'b0;
         key_byte_q   <= 8'h00;
         state_byte_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         key_sh_q     <= key_sh_d;
         data_sh_q    <= data_sh_d;
         out_sh_q     <= out_sh_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         wdog_q       <= wdog_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
         aes_enable_q <= aes_enable_d;
         key_byte_q   <= key_byte_d;
         state_byte_q <= state_byte_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_id         = rsp_id_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign busy           = busy_q;
   assign aes_enable     = aes_enable_q;
   assign aes_key_byte   = key_byte_q;
   assign aes_state_byte = state_byte_q;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench for aes_enc_arbiter with a byte-serial core model that answers
// known FIPS-197 vectors; expected ciphertexts are hand-entered constants.
module tb_aes_enc_arbiter;

   localparam int NR   = 2;
   localparam int TO   = 20;
   localparam int PROC = 5;

   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct { logic err; int id; logic [127:0] data; int cyc; } rsp_t;
   typedef struct { int id; int cyc; } gnt_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*128-1:0] req_key = '0;
   logic [NR*128-1:0] req_data = '0;
   logic [NR-1:0]   req_ready;
   logic            rsp_valid;
   logic [0:0]      rsp_id;
   logic [127:0]    rsp_data;
   logic            rsp_err;
   logic            busy;
   logic            aes_enable;
   logic [7:0]      aes_key_byte;
   logic [7:0]      aes_state_byte;
   logic            aes_load;
   logic            aes_ready = 1'b0;
   logic [7:0]      aes_out_byte = 8'h00;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int onehot_bad = 0, overlap = 0, inv_bad = 0, outstanding = 0;
   int hold_left = 0, low_run = 0, gap_min = 999;
   logic prev_en = 1'b0;
   rsp_t rsp_log[$];
   gnt_t gnt_log[$];

   // core model state
   int cm_phase = 0, cm_cnt = 0, cm_mode = 0;
   logic [127:0] cm_key = '0, cm_pt = '0, cm_ct = '0;

   always #5 clk = ~clk;

   aes_enc_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .aes_enable(aes_enable), .aes_key_byte(aes_key_byte),
      .aes_state_byte(aes_state_byte), .aes_load(aes_load), .aes_ready(aes_ready),
      .aes_out_byte(aes_out_byte)
   );

   function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
      if (k == K0 && p == P0) return C0;
      if (k == K1 && p == P1) return C1;
      return k ^ p;
   endfunction

   assign aes_load = aes_enable && (cm_phase == 0);

   // Byte-serial core: 16 load cycles, PROC busy cycles, one empty ready cycle, 16 output bytes.
   always @(posedge clk) begin
      if (aes_enable !== 1'b1) begin
         cm_phase     <= 0;
         cm_cnt       <= 0;
         aes_ready    <= 1'b0;
         aes_out_byte <= 8'h00;
      end else begin
         case (cm_phase)
            0: begin
               cm_key[127-8*cm_cnt -: 8] <= aes_key_byte;
               cm_pt[127-8*cm_cnt -: 8]  <= aes_state_byte;
               if (cm_cnt == 15) begin cm_phase <= 1; cm_cnt <= 0; end
               else cm_cnt <= cm_cnt + 1;
            end
            1: begin
               if (cm_mode != 1) begin
                  if (cm_cnt == PROC - 1) begin
                     aes_ready <= 1'b1;
                     cm_phase  <= 2;
                     cm_cnt    <= 0;
                     cm_ct     <= ref_ct(cm_key, cm_pt);
                  end else cm_cnt <= cm_cnt + 1;
               end
            end
            2: begin
               if (cm_cnt == 16 || (cm_mode == 2 && cm_cnt == 10)) begin
                  aes_ready <= 1'b0;
                  cm_phase  <= 3;
               end else begin
                  aes_out_byte <= cm_ct[127-8*cm_cnt -: 8];
                  cm_cnt       <= cm_cnt + 1;
               end
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      gnt_t g;
      rsp_t r;
      @(posedge clk); #1;
      cyc++;
      if (req_ready != '0) begin
         if ($countones(req_ready) != 1) onehot_bad++;
         if (outstanding != 0) overlap++;
         outstanding = 1;
         g.id = req_ready[1] ? 1 : 0;
         g.cyc = cyc;
         gnt_log.push_back(g);
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) req_valid = '0;
         end else req_valid = req_valid & ~req_ready;
      end
      if (rsp_valid === 1'b1) begin
         r.err = rsp_err; r.id = int'(rsp_id); r.data = rsp_data; r.cyc = cyc;
         rsp_log.push_back(r);
         outstanding = 0;
      end
      if (aes_enable === 1'b1 && (rsp_valid === 1'b1 || busy !== 1'b1)) inv_bad++;
      if (aes_enable === 1'b1) begin
         if (!prev_en && low_run < gap_min) gap_min = low_run;
         low_run = 0;
      end else low_run++;
      prev_en = (aes_enable === 1'b1);
   endtask

   task automatic wait_rsp(input string tag, output rsp_t r);
      int n0, b;
      n0 = rsp_log.size();
      b = 0;
      while (rsp_log.size() == n0 && b < 300) begin step(); b++; end
      check(tag, 128'(rsp_log.size() > n0), 128'd1);
      if (rsp_log.size() > n0) r = rsp_log[n0];
      else r = '{err: 1'b0, id: -1, data: '0, cyc: 0};
   endtask

   task automatic wait_gnt(input string tag, output gnt_t g);
      int n0, b;
      n0 = gnt_log.size();
      b = 0;
      while (gnt_log.size() == n0 && b < 50) begin step(); b++; end
      check(tag, 128'(gnt_log.size() > n0), 128'd1);
      if (gnt_log.size() > n0) g = gnt_log[n0];
      else g = '{id: -1, cyc: 0};
   endtask

   task automatic check_rsp(input string tag, input rsp_t r, input int id,
                            input logic err, input logic [127:0] data);
      check({tag, "_id"},   128'(r.id), 128'(id));
      check({tag, "_err"},  128'(r.err), 128'(err));
      check({tag, "_data"}, r.data, data);
   endtask

   initial begin
      rsp_t r, r2;
      gnt_t g;
      int n0;

      // reset state
      step(); step();
      check("rst_ctrl", 128'({req_ready, rsp_valid, rsp_id, rsp_err, busy, aes_enable}), 128'd0);
      check("rst_bytes", 128'({aes_key_byte, aes_state_byte}), 128'd0);
      check("rst_data", rsp_data, 128'd0);
      rst = 1'b0;
      step();

      // single FIPS-197 job on requester 0
      req_key[127:0] = K0; req_data[127:0] = P0; req_valid = 2'b01;
      wait_gnt("single_gnt", g);
      check("single_gnt_id", 128'(g.id), 128'd0);
      wait_rsp("single_rsp", r);
      check_rsp("single", r, 0, 1'b0, C0);
      check("single_latency", 128'(r.cyc - g.cyc), 128'd39);
      check("single_core_key", cm_key, K0);
      check("single_core_pt", cm_pt, P0);
      step();
      check("single_idle", 128'({busy, aes_enable, rsp_valid}), 128'd0);

      // contention: both held, rr pointer reset to 0
      rst = 1'b1; step(); rst = 1'b0; outstanding = 0;
      req_key[255:128] = K1; req_data[255:128] = P1;
      hold_left = 4; req_valid = 2'b11;
      for (int j = 0; j < 4; j++) begin
         wait_rsp("cont_rsp", r);
         check_rsp($sformatf("cont%0d", j), r, j % 2, 1'b0, (j % 2 == 0) ? C0 : C1);
         if (gnt_log.size() > 0) check($sformatf("cont%0d_gnt", j),
                                       128'(gnt_log[gnt_log.size()-1].id), 128'(j % 2));
      end
      step(); step();

      // timeout: core never becomes ready
      cm_mode = 1;
      req_valid = 2'b01;
      wait_gnt("to_gnt", g);
      wait_rsp("to_rsp", r);
      check_rsp("to", r, 0, 1'b1, 128'd0);
      check("to_latency", 128'(r.cyc - g.cyc), 128'd38);
      check("to_enable", 128'(aes_enable), 128'd0);
      step();
      check("to_after", 128'({aes_enable, busy, rsp_valid, rsp_err}), 128'd0);
      cm_mode = 0;
      step();

      // reset in the middle of DRAIN, after byte 7 was captured
      req_valid = 2'b10;
      wait_gnt("mid_gnt", g);
      while (cyc < g.cyc + 31) step();
      check("mid_pre_busy", 128'({busy, aes_enable}), 128'd3);
      n0 = rsp_log.size();
      rst = 1'b1; step(); rst = 1'b0; outstanding = 0;
      check("mid_rst_ctrl", 128'({req_ready, rsp_valid, rsp_id, rsp_err, busy, aes_enable}), 128'd0);
      check("mid_rst_bytes", 128'({aes_key_byte, aes_state_byte}), 128'd0);
      check("mid_rst_data", rsp_data, 128'd0);
      for (int j = 0; j < 45; j++) step();
      check("mid_no_rsp", 128'(rsp_log.size()), 128'(n0));
      req_key[255:128] = K0; req_data[255:128] = P0; req_valid = 2'b10;
      wait_rsp("mid_new_rsp", r);
      check_rsp("mid_new", r, 1, 1'b0, C0);
      step();

      // short drain: core drops ready after 10 bytes
      cm_mode = 2;
      req_key[127:0] = K1; req_data[127:0] = P1; req_valid = 2'b01;
      wait_rsp("short_rsp", r);
      check_rsp("short", r, 0, 1'b1, 128'd0);
      step();
      check("short_idle", 128'({busy, aes_enable, rsp_err}), 128'd0);
      cm_mode = 0;
      step();

      // back-to-back on requester 1
      req_key[255:128] = K1; req_data[255:128] = P1; req_valid = 2'b10;
      wait_rsp("b2b_rsp1", r);
      check_rsp("b2b1", r, 1, 1'b0, C1);
      gap_min = 999;
      step();
      req_key[255:128] = K0; req_data[255:128] = P0; req_valid = 2'b10;
      wait_rsp("b2b_rsp2", r2);
      check_rsp("b2b2", r2, 1, 1'b0, C0);
      check("b2b_gap", 128'(gap_min >= 1 && gap_min < 999), 128'd1);
      step();

      check("onehot_ready", 128'(onehot_bad), 128'd0);
      check("no_overlap", 128'(overlap), 128'd0);
      check("enable_invariant", 128'(inv_bad), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
